// File: rtl/hit_resolver_if.sv
// Damage channels from hit_resolver to the two health bars: one valid/ready/amount
// channel per player, carrying damage dealt *to* that player.
interface hit_resolver_if;
  logic       p1_dmg_valid;
  logic [3:0] p1_dmg_amt;
  logic       p1_dmg_ready;
  logic       p2_dmg_valid;
  logic [3:0] p2_dmg_amt;
  logic       p2_dmg_ready;

  modport master (
    output p1_dmg_valid, p1_dmg_amt, p2_dmg_valid, p2_dmg_amt,
    input  p1_dmg_ready, p2_dmg_ready
  );

  modport slave (
    input  p1_dmg_valid, p1_dmg_amt, p2_dmg_valid, p2_dmg_amt,
    output p1_dmg_ready, p2_dmg_ready
  );
endinterface

// File: rtl/hit_resolver.sv
// Frame-rate hit arbitration: folds per-pixel collision flags into one bounded damage
// transaction per player per frame. Define BLOCK_CHIP_DMG_EN to make blocked hits deal raw>>2.
module hit_resolver #(
  parameter logic [3:0] PUNCH_DMG       = 4'd2,
  parameter logic [3:0] KICK_DMG        = 4'd3,
  parameter logic [3:0] BALL_DMG        = 4'd5,
  parameter logic [3:0] COOLDOWN_FRAMES = 4'd8
) (
  input  logic           pixel_Clk,
  input  logic           Reset,
  input  logic           frame_tick,
  input  logic           collision,
  input  logic           ballcollision,
  input  logic           ballcollision2,
  input  logic           punch,
  input  logic           kick,
  input  logic           punch2,
  input  logic           kick2,
  input  logic           block,
  input  logic           block2,
  input  logic           start,
  input  logic           gameover,
  input  logic           gameover2,
  hit_resolver_if.master dmg
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} chan_state_t;

  chan_state_t st1, st2;
  logic [3:0]  amt1, amt2;
  logic [3:0]  cool1, cool2;
  logic        armed1, armed2;
  logic        atk1_q, atk2_q;
  logic        coll_s, ball1_s, ball2_s;

  logic        enable, atk1, atk2;
  logic        coll_e, ball1_e, ball2_e;
  logic        melee1, melee2;
  logic [3:0]  new_dmg1, new_dmg2;

  function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4] ? 4'hF : s[3:0];
  endfunction

  function automatic logic [3:0] blk_adj(input logic [3:0] raw, input logic blocked);
`ifdef BLOCK_CHIP_DMG_EN
    return blocked ? (raw >> 2) : raw;
`else
    return blocked ? 4'd0 : raw;
`endif
  endfunction

  // Flags present in the frame_tick cycle itself still count toward the closing frame.
  always_comb begin
    enable   = start & ~gameover & ~gameover2;
    atk1     = punch | kick;
    atk2     = punch2 | kick2;
    coll_e   = enable & (coll_s | collision);
    ball1_e  = enable & (ball1_s | ballcollision);
    ball2_e  = enable & (ball2_s | ballcollision2);
    melee1   = frame_tick & coll_e & armed1 & (cool1 == '0);
    melee2   = frame_tick & coll_e & armed2 & (cool2 == '0);
    new_dmg1 = '0;
    new_dmg2 = '0;
    if (frame_tick) begin
      new_dmg2 = sat_add(melee1  ? blk_adj(kick ? KICK_DMG : PUNCH_DMG, block2) : 4'd0,
                         ball1_e ? blk_adj(BALL_DMG, block2) : 4'd0);
      new_dmg1 = sat_add(melee2  ? blk_adj(kick2 ? KICK_DMG : PUNCH_DMG, block) : 4'd0,
                         ball2_e ? blk_adj(BALL_DMG, block) : 4'd0);
    end
  end

  always_ff @(posedge pixel_Clk) begin
    if (Reset) begin
      st1     <= IDLE;
      st2     <= IDLE;
      amt1    <= '0;
      amt2    <= '0;
      cool1   <= '0;
      cool2   <= '0;
      armed1  <= 1'b0;
      armed2  <= 1'b0;
      atk1_q  <= 1'b0;
      atk2_q  <= 1'b0;
      coll_s  <= 1'b0;
      ball1_s <= 1'b0;
      ball2_s <= 1'b0;
    end else begin
      atk1_q  <= atk1;
      atk2_q  <= atk2;
      coll_s  <= enable & ~frame_tick & (coll_s | collision);
      ball1_s <= enable & ~frame_tick & (ball1_s | ballcollision);
      ball2_s <= enable & ~frame_tick & (ball2_s | ballcollision2);

      // Arms only on a rising attack edge; a held attack stays armed until it lands.
      armed1 <= enable & atk1 & ~melee1 & (armed1 | ~atk1_q);
      armed2 <= enable & atk2 & ~melee2 & (armed2 | ~atk2_q);

      if (melee1)                      cool1 <= COOLDOWN_FRAMES;
      else if (frame_tick && cool1 != '0) cool1 <= cool1 - 4'd1;
      if (melee2)                      cool2 <= COOLDOWN_FRAMES;
      else if (frame_tick && cool2 != '0) cool2 <= cool2 - 4'd1;

      // new_dmg is zero off frame_tick, so an accept without a tick simply drains.
      case (st1)
        IDLE: if (new_dmg1 != '0) begin
          st1  <= PEND;
          amt1 <= new_dmg1;
        end
        PEND: if (dmg.p1_dmg_ready) begin
          if (new_dmg1 != '0) amt1 <= new_dmg1;
          else begin
            st1  <= IDLE;
            amt1 <= '0;
          end
        end else begin
          amt1 <= sat_add(amt1, new_dmg1);
        end
      endcase

      case (st2)
        IDLE: if (new_dmg2 != '0) begin
          st2  <= PEND;
          amt2 <= new_dmg2;
        end
        PEND: if (dmg.p2_dmg_ready) begin
          if (new_dmg2 != '0) amt2 <= new_dmg2;
          else begin
            st2  <= IDLE;
            amt2 <= '0;
          end
        end else begin
          amt2 <= sat_add(amt2, new_dmg2);
        end
      endcase
    end
  end

  assign dmg.p1_dmg_valid = (st1 == PEND);
  assign dmg.p1_dmg_amt   = amt1;
  assign dmg.p2_dmg_valid = (st2 == PEND);
  assign dmg.p2_dmg_amt   = amt2;

endmodule

// File: doc/hit_resolver.md
# hit_resolver

Frame-rate hit arbitration on the consuming side of the per-pixel `collision`, `ballcollision` and `ballcollision2` flags that the colour mapper raises during scan-out. Over each frame it accumulates those flags and qualifies them against attack, block and cooldown state. At each frame boundary it issues at most one damage transaction per player over a valid/ready channel to the health bars. This replaces raw per-pixel damage counting with one deterministic, bounded hit per attack.

## Interface
Parameters:
- PUNCH_DMG, 2: melee damage for a punch (4-bit units).
- KICK_DMG, 3: melee damage for a kick.
- BALL_DMG, 5: projectile damage.
- COOLDOWN_FRAMES, 8: frames an attacker is locked out after a registered melee hit; range 1..15.

Ports:
- pixel_Clk  in  1  sole clock.
- Reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse marking the end of a frame.
- collision, ballcollision, ballcollision2  in  1 each  per-pixel overlap flags from the colour mapper.
- punch, kick, punch2, kick2  in  1 each  attack states of P1 and P2.
- block, block2  in  1 each  block states of P1 and P2.
- start, gameover, gameover2  in  1 each  round-active and KO status.
- p1_dmg_valid  out  1  damage pending against P1.
- p1_dmg_amt  out  4  damage against P1; held stable while valid.
- p1_dmg_ready  in  1  P1 health bar accepts.
- p2_dmg_valid / p2_dmg_amt / p2_dmg_ready  same as the P1 channel, for damage against P2.

## Operation
- enable = start & !gameover & !gameover2.
- **Sticky latches:** coll_s, ball1_s and ball2_s are set by any cycle in which their flag is high and enable is high. They are cleared on the cycle after frame_tick.
- **Arming:** armed1 sets on the rising edge of (punch|kick) and clears when (punch|kick) is low or when a P1 melee hit registers. armed2 follows the same rules for P2. Holding an attack therefore yields at most one hit.
- **cool1 / cool2:** 4-bit counters.
  - Decremented on frame_tick when nonzero.
  - Loaded with COOLDOWN_FRAMES when that player registers a melee hit; the load overrides the decrement.
- **Evaluation at frame_tick, P1 attacking P2** (P2 attacking P1 is symmetric):
  - Melee hit when coll_s & armed1 & cool1==0. Raw damage is KICK_DMG if kick is high, otherwise PUNCH_DMG; kick takes priority.
  - Projectile hit when ball1_s; raw damage is BALL_DMG. Projectiles ignore cooldown and arming.
  - Damage is the melee term plus the projectile term, each block-adjusted by block2 (see Configuration). The sum saturates at 15.
  - Both players may hit in the same frame (a trade); both channels load independently.
- **Output channel:** two states, IDLE and PEND.
  - IDLE → PEND on frame_tick with nonzero damage.
  - PEND → IDLE when valid & ready and no new nonzero damage arrives in the same cycle.
- **Coalescing:** frame_tick in PEND while ready is low sets amt to sat15(amt + new). No damage is lost.
- **Simultaneous accept and frame_tick:** frame_tick in PEND while ready is high completes the old transfer, then loads the new damage fresh (stay PEND) or goes to IDLE if the new damage is zero.
- **Enable low:** no new hits are registered, and latches and armed are held clear. Pending transactions still drain, so a final blow that causes KO is delivered.
- **Reset:** overrides everything.

## Timing
- Reset values:
  - p1_dmg_valid=0, p2_dmg_valid=0, both amounts 0.
  - cool1=cool2=0; armed, sticky latches and channel states at 0 / IDLE.
- Flags sampled in the frame_tick cycle itself count toward the closing frame.
- Latency: valid and amt are registered, appearing the cycle after frame_tick.
- Transfer occurs on a rising edge with valid & ready. Valid stays high until accepted.
- Ready may be tied high; throughput is one transaction per frame per channel.

## Configuration
- BLOCK_CHIP_DMG_EN defined: a blocked hit deals raw>>2 per term (chip damage), so a blocked kick of 3 deals 0 and a blocked ball of 5 deals 1.
- BLOCK_CHIP_DMG_EN undefined: a blocked hit deals 0. The melee hit still registers (armed clears, cooldown loads).

## Test plan
- Punch rises, collision held for 40 pixels, frame_tick → p2_dmg_valid next cycle with amt=2; a second frame_tick with punch still held → no new damage.
- Kick+punch together, collision, block2=0 → amt=3. The next punch within 8 frames is ignored; a punch on the 9th frame_tick after the hit registers.
- ballcollision with block2=1 → amt=1 with BLOCK_CHIP_DMG_EN, valid stays 0 without it.
- p2_dmg_ready=0 across 4 frames of ball hits → amt 5, 10, 15, 15 (saturation); raising ready gives one transfer, then valid=0.
- collision with armed1 and armed2 both set → both channels valid on the same cycle (trade). With gameover=1, flags are ignored but a pending amt=3 still transfers.
- Reset asserted while PEND with amt=7 → valid=0 and amt=0 next cycle; cooldowns cleared.
